// File: rtl/hblur3_stage.sv
// hblur3_stage: horizontal [1 2 1]/4 smoothing of a 3-pixel-per-beat RGB stream.
// Row edges use pixel replication; a one-beat look-ahead supplies the right neighbour.
module hblur3_stage #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Vsync_in,
  input  logic       Hsync_in,
  input  logic [7:0] R0_in,
  input  logic [7:0] G0_in,
  input  logic [7:0] B0_in,
  input  logic [7:0] R1_in,
  input  logic [7:0] G1_in,
  input  logic [7:0] B1_in,
  input  logic [7:0] R2_in,
  input  logic [7:0] G2_in,
  input  logic [7:0] B2_in,
  output logic       Vsync_out,
  output logic       Hsync_out,
  output logic [7:0] R0_out,
  output logic [7:0] G0_out,
  output logic [7:0] B0_out,
  output logic [7:0] R1_out,
  output logic [7:0] G1_out,
  output logic [7:0] B1_out,
  output logic [7:0] R2_out,
  output logic [7:0] G2_out,
  output logic [7:0] B2_out,
  output logic       frame_done
);

  localparam int BEATS = WIDTH / 3;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);

  // Beats are packed as byte (lane*3 + channel), channel 0/1/2 = R/G/B.
  logic [71:0]   in_beat;
  logic [71:0]   prev;
  logic [71:0]   filt;
  logic [71:0]   out_beat;
  logic [23:0]   left;
  logic [23:0]   right;
  logic [CW-1:0] col;
  logic [CW-1:0] col_eff;
  logic [RW-1:0] row;
  logic          flush;
  logic          prev_valid;
  logic          load_first;
  logic          emit_beat;
  logic          emit_flush;

  function automatic logic [7:0] tap(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c);
    return 8'(({2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c} + 10'd2) >> 2);
  endfunction

  assign in_beat = {B2_in, G2_in, R2_in, B1_in, G1_in, R1_in, B0_in, G0_in, R0_in};

  assign {B2_out, G2_out, R2_out, B1_out, G1_out, R1_out, B0_out, G0_out, R0_out} = out_beat;

  // A flush (last beat of a row) replicates its own rightmost pixel.
  always_comb begin
    right = flush ? prev[71:48] : in_beat[23:0];
    filt  = '0;
    for (int ch = 0; ch < 3; ch++) begin
      filt[8*ch     +: 8] = tap(left[8*ch +: 8], prev[8*ch +: 8], prev[8*(3+ch) +: 8]);
      filt[8*(3+ch) +: 8] = tap(prev[8*ch +: 8], prev[8*(3+ch) +: 8], prev[8*(6+ch) +: 8]);
      filt[8*(6+ch) +: 8] = tap(prev[8*(3+ch) +: 8], prev[8*(6+ch) +: 8], right[8*ch +: 8]);
    end
  end

  assign emit_flush = !Vsync_in && flush && prev_valid;
  assign load_first = Hsync_in && (Vsync_in || flush || col == '0);
  assign emit_beat  = Hsync_in && !load_first && prev_valid;
  assign col_eff    = load_first ? '0 : col;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      Vsync_out  <= 1'b0;
      Hsync_out  <= 1'b0;
      frame_done <= 1'b0;
      out_beat   <= '0;
      prev       <= '0;
      left       <= '0;
      col        <= '0;
      row        <= '0;
      flush      <= 1'b0;
      prev_valid <= 1'b0;
    end else begin
      Vsync_out  <= Vsync_in;
      Hsync_out  <= emit_flush || emit_beat;
      frame_done <= emit_flush && (row == LAST_ROW);
      if (emit_flush || emit_beat)
        out_beat <= filt;

      if (Vsync_in) begin
        col        <= '0;
        row        <= '0;
        flush      <= 1'b0;
        prev_valid <= 1'b0;
      end else if (emit_flush) begin
        flush      <= 1'b0;
        prev_valid <= 1'b0;
        row        <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end

      // Later assignments here override the clears above when a new row starts on the same edge.
      if (Hsync_in) begin
        prev       <= in_beat;
        prev_valid <= 1'b1;
        left       <= load_first ? in_beat[23:0] : prev[71:48];
        if (col_eff == LAST_COL) begin
          flush <= 1'b1;
          col   <= '0;
        end else begin
          col <= col_eff + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hblur3_stage.sv
// Bench for hblur3_stage: a 6x2 instance for row/frame behaviour and a 3x1 instance
// for the single-beat-row case, both checked against a per-pixel arithmetic model.
module tb_hblur3_stage;

  localparam int W = 6;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic        vs_a, hs_a, vs_b, hs_b;
  logic [71:0] in_a, in_b, out_a, out_b;
  logic [7:0]  oa [9];
  logic [7:0]  ob [9];
  logic        vso_a, hso_a, fd_a, vso_b, hso_b, fd_b;

  int          tests_run = 0;
  int          failed    = 0;
  int          stray_fd  = 0;
  int          exp_row   = 0;
  int          pix [3][6];
  logic [72:0] got_q [$];
  logic [72:0] exp_q [$];

  always #5 clk = ~clk;

  hblur3_stage #(.WIDTH(6), .HEIGHT(2)) dut_a (
    .clk(clk), .Reset(Reset), .Vsync_in(vs_a), .Hsync_in(hs_a),
    .R0_in(in_a[7:0]),   .G0_in(in_a[15:8]),  .B0_in(in_a[23:16]),
    .R1_in(in_a[31:24]), .G1_in(in_a[39:32]), .B1_in(in_a[47:40]),
    .R2_in(in_a[55:48]), .G2_in(in_a[63:56]), .B2_in(in_a[71:64]),
    .Vsync_out(vso_a), .Hsync_out(hso_a),
    .R0_out(oa[0]), .G0_out(oa[1]), .B0_out(oa[2]),
    .R1_out(oa[3]), .G1_out(oa[4]), .B1_out(oa[5]),
    .R2_out(oa[6]), .G2_out(oa[7]), .B2_out(oa[8]),
    .frame_done(fd_a)
  );

  hblur3_stage #(.WIDTH(3), .HEIGHT(1)) dut_b (
    .clk(clk), .Reset(Reset), .Vsync_in(vs_b), .Hsync_in(hs_b),
    .R0_in(in_b[7:0]),   .G0_in(in_b[15:8]),  .B0_in(in_b[23:16]),
    .R1_in(in_b[31:24]), .G1_in(in_b[39:32]), .B1_in(in_b[47:40]),
    .R2_in(in_b[55:48]), .G2_in(in_b[63:56]), .B2_in(in_b[71:64]),
    .Vsync_out(vso_b), .Hsync_out(hso_b),
    .R0_out(ob[0]), .G0_out(ob[1]), .B0_out(ob[2]),
    .R1_out(ob[3]), .G1_out(ob[4]), .B1_out(ob[5]),
    .R2_out(ob[6]), .G2_out(ob[7]), .B2_out(ob[8]),
    .frame_done(fd_b)
  );

  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int i = 0; i < 9; i++) begin
      out_a[8*i +: 8] = oa[i];
      out_b[8*i +: 8] = ob[i];
    end
  end

  // Every output beat of the 6x2 instance is captured with its frame_done flag.
  always @(negedge clk) begin
    if (hso_a) got_q.push_back({fd_a, out_a});
    if (fd_a && !hso_a) stray_fd++;
  end

  function automatic logic [71:0] rand_beat();
    return 72'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic [71:0] pack_beat(input int k);
    logic [71:0] b;
    b = '0;
    for (int lane = 0; lane < 3; lane++)
      for (int ch = 0; ch < 3; ch++)
        b[8*(lane*3+ch) +: 8] = 8'(pix[ch][3*k+lane]);
    return b;
  endfunction

  // Filtered beat k of the row held in pix, with edge replication at x=0 and x=w-1.
  function automatic logic [71:0] model_beat(input int k, input int w);
    logic [71:0] b;
    int x, xl, xr, v;
    b = '0;
    for (int lane = 0; lane < 3; lane++)
      for (int ch = 0; ch < 3; ch++) begin
        x  = 3*k + lane;
        xl = (x == 0) ? 0 : x - 1;
        xr = (x == w - 1) ? x : x + 1;
        v  = (pix[ch][xl] + 2*pix[ch][x] + pix[ch][xr] + 2) / 4;
        b[8*(lane*3+ch) +: 8] = 8'(v);
      end
    return b;
  endfunction

  task automatic model_row();
    for (int k = 0; k < W/3; k++)
      exp_q.push_back({(k == W/3 - 1) && (exp_row == H - 1), model_beat(k, W)});
    exp_row = (exp_row + 1) % H;
  endtask

  task automatic fill_pix(input int lo, input int hi);
    for (int ch = 0; ch < 3; ch++)
      for (int x = 0; x < 6; x++)
        pix[ch][x] = int'($urandom_range(hi, lo));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input logic vs, input logic hs, input logic [71:0] b);
    vs_a = vs; hs_a = hs; in_a = b;
    @(posedge clk);
    #1;
    vs_a = 1'b0; hs_a = 1'b0; in_a = rand_beat();
  endtask

  task automatic drive_b(input logic vs, input logic hs, input logic [71:0] b);
    vs_b = vs; hs_b = hs; in_b = b;
    @(posedge clk);
    #1;
    vs_b = 1'b0; hs_b = 1'b0; in_b = rand_beat();
  endtask

  task automatic send_row(input int gapmax, input bit with_vs);
    int gap;
    for (int k = 0; k < W/3; k++) begin
      gap = int'($urandom_range(gapmax, 0));
      if (with_vs && k == 0 && gap == 0) gap = 1;
      wait_cycles(gap);
      drive_a(with_vs && k == 0, 1'b1, pack_beat(k));
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vs_a = 1'($urandom()); hs_a = 1'($urandom()); in_a = rand_beat();
      vs_b = 1'($urandom()); hs_b = 1'($urandom()); in_b = rand_beat();
      @(posedge clk);
      #1;
      tests_run++;
      if ({vso_a, hso_a, fd_a, out_a} !== 75'd0) begin
        failed++;
        $display("[TB] FAIL reset_a cycle %0d: got %h expected 0", i, {vso_a, hso_a, fd_a, out_a});
      end
      tests_run++;
      if ({vso_b, hso_b, fd_b, out_b} !== 75'd0) begin
        failed++;
        $display("[TB] FAIL reset_b cycle %0d: got %h expected 0", i, {vso_b, hso_b, fd_b, out_b});
      end
    end
    vs_a = 1'b0; hs_a = 1'b0; vs_b = 1'b0; hs_b = 1'b0;
    Reset = 1'b1;
    wait_cycles(2);
    got_q.delete();
    exp_q.delete();
    exp_row = 0;
  endtask

  task automatic test_flat();
    drive_a(1'b1, 1'b0, rand_beat());
    tests_run++;
    if (vso_a !== 1'b1) begin
      failed++;
      $display("[TB] FAIL vsync_delay: got %b expected 1", vso_a);
    end
    wait_cycles(1);
    tests_run++;
    if (vso_a !== 1'b0) begin
      failed++;
      $display("[TB] FAIL vsync_drop: got %b expected 0", vso_a);
    end
    for (int ch = 0; ch < 3; ch++)
      for (int x = 0; x < 6; x++) pix[ch][x] = 100;
    exp_row = 1;
    send_row(2, 1'b0);
    exp_q.push_back({1'b0, {9{8'd100}}});
    exp_q.push_back({1'b0, {9{8'd100}}});
    wait_cycles(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("[TB] FAIL flat_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL flat_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Row 1 of the frame: a single bright R pixel at x=2, so frame_done rides the 2nd beat.
  task automatic test_impulse();
    for (int ch = 0; ch < 3; ch++)
      for (int x = 0; x < 6; x++) pix[ch][x] = 0;
    pix[0][2] = 255;
    send_row(1, 1'b0);
    exp_q.push_back({1'b0, 72'h00_00_80_00_00_40_00_00_00});
    exp_q.push_back({1'b1, 72'h00_00_00_00_00_00_00_00_40});
    exp_row = 0;
    wait_cycles(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("[TB] FAIL impulse_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL impulse_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_narrow();
    logic [71:0] exp_b;
    exp_b = '0;
    for (int r = 0; r < 4; r++) begin
      fill_pix(0, 255);
      if (r == 0) begin
        pix[0][0] = 10; pix[0][1] = 20; pix[0][2] = 30;
      end
      exp_b = model_beat(0, 3);
      wait_cycles(int'($urandom_range(2, 0)));
      drive_b(1'b0, 1'b1, pack_beat(0));
      tests_run++;
      if (hso_b !== 1'b0) begin
        failed++;
        $display("[TB] FAIL narrow_early%0d: got hsync %b expected 0", r, hso_b);
      end
      wait_cycles(1);
      tests_run++;
      if ({fd_b, hso_b, out_b} !== {2'b11, exp_b}) begin
        failed++;
        $display("[TB] FAIL narrow_beat%0d: got %h expected %h", r, {fd_b, hso_b, out_b}, {2'b11, exp_b});
      end
      if (r == 0) begin
        tests_run++;
        if ({out_b[55:48], out_b[31:24], out_b[7:0]} !== {8'd28, 8'd20, 8'd13}) begin
          failed++;
          $display("[TB] FAIL narrow_red: got %h expected 1c140d",
                   {out_b[55:48], out_b[31:24], out_b[7:0]});
        end
      end
    end
    wait_cycles(1);
    tests_run++;
    if ({hso_b, fd_b, out_b} !== {2'b00, exp_b}) begin
      failed++;
      $display("[TB] FAIL narrow_hold: got %h expected %h", {hso_b, fd_b, out_b}, {2'b00, exp_b});
    end
  endtask

  task automatic test_back_to_back();
    wait_cycles(1);
    drive_a(1'b1, 1'b0, rand_beat());
    for (int ch = 0; ch < 3; ch++)
      for (int x = 0; x < 6; x++) pix[ch][x] = 200;
    send_row(0, 1'b0);
    for (int ch = 0; ch < 3; ch++)
      for (int x = 0; x < 6; x++) pix[ch][x] = 0;
    send_row(0, 1'b0);
    exp_q.push_back({1'b0, {9{8'd200}}});
    exp_q.push_back({1'b0, {9{8'd200}}});
    exp_q.push_back({1'b0, 72'd0});
    exp_q.push_back({1'b1, 72'd0});
    exp_row = 0;
    wait_cycles(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("[TB] FAIL b2b_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL b2b_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_abort();
    fill_pix(0, 255);
    drive_a(1'b0, 1'b1, pack_beat(0));
    Reset = 1'b0;
    wait_cycles(1);
    Reset = 1'b1;
    exp_row = 0;
    fill_pix(0, 255);
    send_row(2, 1'b0);
    model_row();
    wait_cycles(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("[TB] FAIL abort_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL abort_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Random frames with intra-row gaps; some frames begin after a discarded partial row.
  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(1, 0) == 1) begin
        fill_pix(0, 255);
        drive_a(1'b0, 1'b1, pack_beat(0));
      end
      for (int r = 0; r < H; r++) begin
        fill_pix(0, 255);
        if (r == 0) exp_row = 0;
        send_row(2, r == 0);
        model_row();
      end
    end
    wait_cycles(4);
    tests_run++;
    if (got_q.size() != exp_q.size()) begin
      failed++;
      $display("[TB] FAIL random_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin
        failed++;
        $display("[TB] FAIL random_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (stray_fd != 0) begin
      failed++;
      $display("[TB] FAIL stray_frame_done: got %0d pulses without Hsync_out expected 0", stray_fd);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    Reset = 1'b0;
    vs_a = 1'b0; hs_a = 1'b0; in_a = '0;
    vs_b = 1'b0; hs_b = 1'b0; in_b = '0;
    test_reset();
    test_flat();
    test_impulse();
    test_narrow();
    test_back_to_back();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
